// File: rtl/sys_defs.sv
// Shared processor-wide widths, register-index type and reserved
// register constants.
package sys_defs;

    localparam int PHYS_REG_NUM = 64;
    localparam int ARCH_REG_NUM = 32;
    localparam int PREG_IDX_W   = 6;

    typedef logic [PREG_IDX_W-1:0] PREG;

    localparam PREG ZERO_PREG = '0;

endpackage

// File: rtl/free_list.sv
// Physical register free list: circular FIFO of free PREGs with a
// checkpointable head pointer for branch-mispredict rollback.
module free_list
    import sys_defs::*;
#(
    parameter int FL_DEPTH = PHYS_REG_NUM - ARCH_REG_NUM,
    parameter int FL_BASE  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enqueue_en,
    input  PREG                   enqueue_pr,
    input  logic                  dequeue_en,
    input  logic                  undo,
    input  logic [PREG_IDX_W-1:0] undo_head,
    output PREG                   free_reg,
    output logic                  is_empty,
    output logic                  is_full,
    output logic [PREG_IDX_W-1:0] count,
    output logic [PREG_IDX_W-1:0] head_ptr,
    output logic                  overflow
);

    localparam int IDX_W = $clog2(FL_DEPTH);

    PREG                   entry [FL_DEPTH];
    logic [PREG_IDX_W-1:0] head;
    logic [PREG_IDX_W-1:0] tail;
    logic                  pr_nonzero;
    logic                  do_enq;
    logic                  do_deq;
    logic                  ovf_set;

    assign count    = tail - head;
    assign is_empty = (count == '0);
    assign is_full  = (count == PREG_IDX_W'(FL_DEPTH));
    assign free_reg = is_empty ? ZERO_PREG : entry[head[IDX_W-1:0]];
    assign head_ptr = head;

    // Full is judged on the pre-edge count, so a same-cycle dequeue
    // or undo never makes room for the enqueue.
    assign pr_nonzero = (enqueue_pr != ZERO_PREG);
    assign do_enq     = enqueue_en && pr_nonzero && !is_full;
    assign ovf_set    = enqueue_en && pr_nonzero && is_full;
    assign do_deq     = dequeue_en && !is_empty && !undo;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                entry[i] <= PREG'(FL_BASE + i);
            end
            head     <= '0;
            tail     <= PREG_IDX_W'(FL_DEPTH);
            overflow <= 1'b0;
        end else begin
            if (do_enq) begin
                entry[tail[IDX_W-1:0]] <= enqueue_pr;
                tail                   <= tail + 1'b1;
            end
            // Rolled-back entries are still intact in the array; restoring
            // head is enough to hand them out again.
            if (undo) begin
                head <= undo_head;
            end else if (do_deq) begin
                head <= head + 1'b1;
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: stimulus pushes per-cycle expectations,
// a monitor pops and compares them on the falling edge.
module tb_free_list;
    import sys_defs::*;

    logic                  clock;
    logic                  reset;
    logic                  enqueue_en;
    PREG                   enqueue_pr;
    logic                  dequeue_en;
    logic                  undo;
    logic [PREG_IDX_W-1:0] undo_head;
    PREG                   free_reg;
    logic                  is_empty;
    logic                  is_full;
    logic [PREG_IDX_W-1:0] count;
    logic [PREG_IDX_W-1:0] head_ptr;
    logic                  overflow;

    free_list dut (
        .clock      (clock),
        .reset      (reset),
        .enqueue_en (enqueue_en),
        .enqueue_pr (enqueue_pr),
        .dequeue_en (dequeue_en),
        .undo       (undo),
        .undo_head  (undo_head),
        .free_reg   (free_reg),
        .is_empty   (is_empty),
        .is_full    (is_full),
        .count      (count),
        .head_ptr   (head_ptr),
        .overflow   (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string      nm;
        PREG        fr;
        logic [5:0] cnt;
        logic [5:0] hp;
        logic       ovf;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   stim_done = 0;

    // Expected outputs describe the cycle in which the inputs are applied,
    // i.e. the state left by the previous edge.
    task automatic step(input string nm, input logic enq, input PREG pr,
                        input logic deq, input logic un,
                        input logic [5:0] uh, input PREG efr,
                        input logic [5:0] ecnt, input logic [5:0] ehp,
                        input logic eovf);
        exp_t e;
        enqueue_en = enq;
        enqueue_pr = pr;
        dequeue_en = deq;
        undo       = un;
        undo_head  = uh;
        e.nm  = nm;
        e.fr  = efr;
        e.cnt = ecnt;
        e.hp  = ehp;
        e.ovf = eovf;
        q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic enq, input logic deq, input logic un);
        reset      = 1'b1;
        enqueue_en = enq;
        enqueue_pr = 6'd50;
        dequeue_en = deq;
        undo       = un;
        undo_head  = 6'd5;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            logic ee;
            logic ef;
            e  = q.pop_front();
            ee = (e.cnt == 6'd0);
            ef = (e.cnt == 6'd32);
            n_tests++;
            if (free_reg !== e.fr || count !== e.cnt || head_ptr !== e.hp ||
                overflow !== e.ovf || is_empty !== ee || is_full !== ef) begin
                n_fail++;
                $display("FAIL %s: got fr=%0d cnt=%0d hp=%0d ovf=%b emp=%b full=%b want fr=%0d cnt=%0d hp=%0d ovf=%b emp=%b full=%b",
                         e.nm, free_reg, count, head_ptr, overflow, is_empty,
                         is_full, e.fr, e.cnt, e.hp, e.ovf, ee, ef);
            end
        end
    end

    initial begin
        reset      = 1'b0;
        enqueue_en = 1'b0;
        enqueue_pr = '0;
        dequeue_en = 1'b0;
        undo       = 1'b0;
        undo_head  = '0;
        @(posedge clock);
        #1;
        do_reset(1'b0, 1'b0, 1'b0);

        step("reset", 0, 0, 0, 0, 0, 6'd32, 6'd32, 6'd0, 0);
        for (int i = 0; i < 32; i++) begin
            step("drain", 0, 0, 1, 0, 0, PREG'(32 + i), 6'(32 - i), 6'(i), 0);
        end
        step("empty", 0, 0, 1, 0, 0, 6'd0, 6'd0, 6'd32, 0);
        step("deq_empty", 0, 0, 0, 0, 0, 6'd0, 6'd0, 6'd32, 0);

        step("enq40_same", 1, 6'd40, 1, 0, 0, 6'd0, 6'd0, 6'd32, 0);
        step("enq40_next", 0, 0, 0, 0, 0, 6'd40, 6'd1, 6'd32, 0);
        for (int k = 0; k < 4; k++) begin
            step("fill5", 1, PREG'(41 + k), 0, 0, 0, 6'd40, 6'(1 + k), 6'd32, 0);
        end
        step("enq0", 1, 6'd0, 0, 0, 0, 6'd40, 6'd5, 6'd32, 0);
        step("enq0_after", 0, 0, 0, 0, 0, 6'd40, 6'd5, 6'd32, 0);

        // Tail crosses index 31 and wraps to 0 on the way to full.
        for (int k = 0; k < 27; k++) begin
            step("fill32", 1, PREG'(10 + k), 0, 0, 0, 6'd40, 6'(5 + k), 6'd32, 0);
        end
        step("full", 1, 6'd45, 0, 0, 0, 6'd40, 6'd32, 6'd32, 0);
        step("ovf_set", 1, 6'd46, 1, 0, 0, 6'd40, 6'd32, 6'd32, 1);
        step("full_enq_deq", 0, 0, 0, 0, 0, 6'd41, 6'd31, 6'd33, 1);

        do_reset(1'b1, 1'b1, 1'b1);
        step("reset_mid", 0, 0, 1, 0, 0, 6'd32, 6'd32, 6'd0, 0);
        step("deq2", 0, 0, 1, 0, 0, 6'd33, 6'd31, 6'd1, 0);
        step("deq3", 0, 0, 1, 0, 0, 6'd34, 6'd30, 6'd2, 0);
        step("undo_cyc", 0, 0, 1, 1, 6'd1, 6'd35, 6'd29, 6'd3, 0);
        step("undo_after", 0, 0, 0, 0, 0, 6'd33, 6'd31, 6'd1, 0);

        for (int i = 0; i < 21; i++) begin
            step("to10", 0, 0, 1, 0, 0, PREG'(33 + i), 6'(31 - i), 6'(1 + i), 0);
        end
        step("cnt10", 1, 6'd50, 1, 0, 0, 6'd54, 6'd10, 6'd22, 0);
        for (int i = 0; i < 10; i++) begin
            step("enqdeq_drain", 0, 0, 1, 0, 0,
                 (i < 9) ? PREG'(55 + i) : PREG'(50), 6'(10 - i), 6'(23 + i), 0);
        end
        step("undo_enq", 1, 6'd60, 0, 1, 6'd31, 6'd0, 6'd0, 6'd33, 0);
        step("undo_enq_after", 0, 0, 0, 0, 0, 6'd63, 6'd3, 6'd31, 0);
        step("undo_enq_tail", 0, 0, 0, 0, 0, 6'd63, 6'd3, 6'd31, 0);

        enqueue_en = 1'b0;
        dequeue_en = 1'b0;
        undo       = 1'b0;
        stim_done  = 1'b1;
    end

    initial begin
        wait (stim_done);
        for (int t = 0; t < 10 && q.size() > 0; t++) @(negedge clock);
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL take parameter FL_DEPTH, default 32, the number of entries: PHYS_REG_NUM minus ARCH_REG_NUM.
REQ-002 SHALL take parameter FL_BASE, default 32, the first physical register loaded at reset.
REQ-003 SHALL have input clock, 1 bit, the rising-edge clock.
REQ-004 SHALL have input reset, 1 bit, synchronous, active-high.
REQ-005 SHALL have input enqueue_en, 1 bit: the retire stage is freeing one register.
REQ-006 SHALL have input enqueue_pr, PREG_IDX_W (6) bits: the physical register being freed (the retiring Told).
REQ-007 SHALL have input dequeue_en, 1 bit: dispatch is consuming free_reg this cycle.
REQ-008 SHALL have output free_reg, 6 bits: the register at the head; ZERO_PREG (0) when empty.
REQ-009 SHALL have output is_empty, 1 bit, and output is_full, 1 bit.
REQ-010 SHALL have output count, 6 bits: the valid entries, 0..FL_DEPTH.
REQ-011 SHALL have output head_ptr, 6 bits (5-bit index plus wrap bit): the current head, checkpointed by dispatch per instruction.
REQ-012 SHALL have input undo, 1 bit, and input undo_head, 6 bits: branch-mispredict rollback to a checkpointed head_ptr.
REQ-013 SHALL have output overflow, 1 bit: a sticky error flag.

Function
REQ-014 SHALL be a circular FIFO of FL_DEPTH PREG entries with 6-bit head and tail pointers; the low 5 bits index and the MSB is the wrap bit.
REQ-015 SHALL compute count = (tail - head) mod 64, is_empty = (count==0) and is_full = (count==FL_DEPTH), all combinationally from the registered pointers.
REQ-016 SHALL drive free_reg combinationally from entry[head[4:0]], forced to 0 when is_empty.
REQ-017 SHALL, on dequeue_en with !is_empty and !undo, advance head by 1 at the clock edge; dequeue_en while empty is ignored with no pointer change.
REQ-018 SHALL, on enqueue_en with enqueue_pr != 0 and !is_full, write entry[tail[4:0]] and advance tail by 1 at the edge.
REQ-019 SHALL drop enqueue_en with enqueue_pr==0 silently; the zero register is never freed.
REQ-020 SHALL drop enqueue_en while is_full and set overflow at that edge; overflow holds until reset.
REQ-021 SHALL allow an enqueued register to be dequeued no earlier than the next cycle; there is no enqueue-to-dequeue bypass.
REQ-022 SHALL, when enqueue and dequeue occur in the same cycle (non-empty, non-full), advance both pointers, leaving count unchanged.
REQ-023 SHALL, when full and enqueue and dequeue occur in the same cycle, drop the enqueue (full is evaluated on pre-edge count) and set overflow.
REQ-024 SHALL, on undo, load head <= undo_head and ignore dequeue_en that cycle; a same-cycle enqueue still proceeds against the pre-undo is_full.
REQ-025 SHALL leave entries between undo_head and the old head unmodified by undo; they become free again purely through the pointer restore.
REQ-026 SHALL keep head_ptr equal to the registered head, so the value sampled alongside a dequeue is the pre-dequeue pointer.
REQ-027 SHALL wrap both pointers modulo 64; the index wraps at FL_DEPTH=32 with the wrap bit toggling.

Reset
REQ-028 SHALL, on reset, load entry[i] = FL_BASE+i for i=0..31, head=0, tail=32 (index 0, wrap bit 1), and overflow=0.
REQ-029 SHALL, one cycle after reset, have count=32, is_full=1, is_empty=0, free_reg=32 and head_ptr=0.
REQ-030 SHALL let reset override undo, enqueue and dequeue in the same cycle, including reset asserted mid-stream.

Structure
REQ-031 SHALL take PREG (6-bit typedef), PHYS_REG_NUM=64, ARCH_REG_NUM=32, PREG_IDX_W=6 and ZERO_PREG=0 from the shared sys_defs package.
REQ-032 SHALL be a single module with no sub-modules: one entry array, two pointer registers, one overflow flop, and combinational flag/output logic.

Verification
REQ-033 SHALL cover: reset then 32 back-to-back dequeues -> free_reg sequence 32..63, then is_empty=1 and free_reg=0.
REQ-034 SHALL cover: from empty, enqueue 40 at cycle n with dequeue held -> free_reg=40 at n+1, not at n; count=1.
REQ-035 SHALL cover: from full, enqueue 45 -> dropped, overflow=1, count stays 32; enqueue 0 from count=5 -> count stays 5.
REQ-036 SHALL cover: dequeue 3 regs (head_ptr 0->3), save head_ptr=1 after the first, then undo with undo_head=1 -> count=31, free_reg=33.
REQ-037 SHALL cover: count=10 with enqueue 50 and dequeue in the same cycle -> count=10, head and tail both +1.
REQ-038 SHALL cover: drive tail across index 31 -> wrap bit toggles, count correct, and is_full asserts at 32.
